vec_elem_seq: RTL and testbench
===============================

# vec_elem_seq

Element sequencer for multi-cycle RVV instructions. It sits beside the ID stage and accepts one decoded vector instruction. It stalls the scalar front end, then issues one element operation per cycle to the shared execution lane until `vl` elements have been issued and written back. A credit counter bounds the number of in-flight elements, and a flush aborts the instruction cleanly.

## Interface
- `MAX_VL`, 32: largest supported vector length; `csr_vl` values above it are clamped to it.
- `MAX_OUT`, 4: maximum number of elements issued but not yet written back.
- `VL_W`, $clog2(MAX_VL)+1: width of the vl and index fields.
- `clock` in 1: the only clock. Reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high.
- `vec_valid` in 1: ID presents a vector instruction.
- `vec_ready` out 1: the sequencer accepts the instruction this cycle.
- `vec_vd`, `vec_vs1`, `vec_vs2` in 5 each: register fields of the presented instruction.
- `csr_vl` in VL_W: current `vl` from the CSR file; sampled at acceptance.
- `elem_valid` out 1: an element operation is presented to the lane.
- `elem_ready` in 1: the lane takes the element.
- `elem_idx` out VL_W: index of the presented element.
- `elem_vd`, `elem_vs1`, `elem_vs2` out 5 each: latched register fields.
- `elem_last` out 1: `elem_idx == vl-1`.
- `wb_ack` in 1: one element has completed writeback.
- `flush` in 1: kills the current instruction (mispredict or exception).
- `stall_pipe` out 1: holds IF/ID.
- `busy` out 1: the state is not IDLE.
- `done` out 1: one-cycle pulse when an instruction completes.

## Operation
- States: IDLE, ISSUE, DRAIN, encoded in 2 bits.
- **IDLE**
  - `vec_ready = !reset && !flush`.
  - Acceptance (`vec_valid && vec_ready`) latches the three register fields and `vl = min(csr_vl, MAX_VL)`, and clears `idx`.
  - After acceptance the next state is ISSUE if `vl != 0`, otherwise DRAIN.
- **ISSUE**
  - `elem_valid = (out_cnt < MAX_OUT) && !flush`.
  - A transfer (`elem_valid && elem_ready`) increments `idx` and `out_cnt`.
  - A transfer with `elem_last` moves the state to DRAIN.
- **DRAIN**
  - No elements are issued.
  - When the effective count is zero, the state moves to IDLE and `done` is set for one cycle. The effective count is `out_cnt` minus 1 if `wb_ack` is high this cycle.
- `out_cnt` (width $clog2(MAX_OUT)+1) counts +1 per transfer and -1 per `wb_ack`. A transfer and a `wb_ack` in the same cycle leave it unchanged. A `wb_ack` at zero is ignored and the count saturates at 0.
- `wb_ack` is honoured in both ISSUE and DRAIN.
- `stall_pipe = busy`. The accepted instruction leaves ID as a bubble, and younger instructions wait in ID.
- `flush` in any state:
  - next state is IDLE and `out_cnt` is cleared;
  - `elem_valid` and `vec_ready` are forced low in the same cycle;
  - no `done` is produced, and `wb_ack` is ignored in that cycle.
- The element register fields and `elem_idx` stay stable while `elem_valid && !elem_ready`.

## Timing
- Acceptance at cycle T: `busy`/`stall_pipe` rise at T+1, and the first `elem_valid` appears at T+1 with `elem_idx=0`.
- With `elem_ready` held high and credits available, the sequencer issues one element per cycle.
- `done` is registered and is high in the first IDLE cycle after DRAIN.
- `vec_ready` can be high in that same cycle, so back-to-back instructions are possible.
- A `wb_ack` in cycle C frees a credit that is visible as `elem_valid` at C+1.
- Reset (synchronous, checked at the clock edge) overrides everything, including mid-ISSUE or mid-DRAIN. All registered outputs and `out_cnt` clear to 0, the state goes to IDLE, and `done` stays 0. `vec_ready` is 0 while reset is high and 1 in the first cycle after it.

## Structure
- The state encodings (`VSEQ_IDLE`, `VSEQ_ISSUE`, `VSEQ_DRAIN`) and the `MAX_VL`/`MAX_OUT` defaults go in the shared `constants.vh`.
- One sub-module, `vseq_credit_cnt`, implements the saturating up/down `out_cnt` with inputs inc, dec and clr, and outputs count and full.
- The FSM, the latches and the index counter stay in `vec_elem_seq`.

## Test plan
- **vl=4, ready=1, `wb_ack` one cycle after each transfer, accept at T:** `elem_idx` 0..3 at T+1..T+4; `elem_last` at T+4; DRAIN at T+5; `done` and `vec_ready` at T+6.
- **vl=0:** no `elem_valid`; DRAIN at T+1; `done` at T+2; `busy` high only during T+1.
- **MAX_OUT=4, vl=8, no `wb_ack`:** 4 transfers at T+1..T+4, then `elem_valid` low. A single `wb_ack` at T+7 gives `elem_valid` with `elem_idx=4` at T+8.
- **`elem_ready` low for 3 cycles at idx 2:** `elem_idx`, `elem_vd`, `elem_vs1` and `elem_vs2` stay constant; `out_cnt` stays constant.
- **`flush` during ISSUE at idx 2 of vl=8:** `elem_valid` is 0 in the flush cycle; IDLE next cycle with `out_cnt=0`; no `done`. A new instruction is accepted one cycle later.
- **`csr_vl=40` with MAX_VL=32, and reset asserted in DRAIN:** 32 elements are issued (last `elem_idx=31`). Reset returns all outputs to 0, `done` is never pulsed, and `vec_ready` is 1 the cycle after reset drops.

Source files
------------

// File: rtl/vec_elem_seq_pkg.sv
// Shared definitions for the vector element sequencer.
// Holds the sequencer state encoding and the default limits for the
// supported vector length and the number of in-flight elements.
package vec_elem_seq_pkg;

  typedef enum logic [1:0] {
    VSEQ_IDLE  = 2'd0,
    VSEQ_ISSUE = 2'd1,
    VSEQ_DRAIN = 2'd2
  } vseqState_e;

  localparam int unsigned VSEQ_MAX_VL  = 32;
  localparam int unsigned VSEQ_MAX_OUT = 4;

endpackage

// File: rtl/vec_elem_seq_credit_cnt.sv
// vseq_credit_cnt: saturating up/down counter of elements issued to the
// lane but not yet written back.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   inc          : one element transferred this cycle
//   dec          : one element written back this cycle (ignored at zero)
//   clr          : abort, count returns to zero (dominates inc/dec)
//   count        : current in-flight count
//   full         : count has reached MAX_OUT, no further issue allowed
module vseq_credit_cnt
  import vec_elem_seq_pkg::*;
#(
  parameter int unsigned MAX_OUT = VSEQ_MAX_OUT,
  parameter int unsigned CNT_W   = $clog2(MAX_OUT) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  logic [CNT_W-1:0] cnt;
  logic             decEff;

  // A writeback with nothing outstanding is spurious and must not wrap.
  assign decEff = dec && (cnt != '0);

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (inc && !decEff) begin
      cnt <= cnt + CNT_W'(1);
    end else if (decEff && !inc) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign count = cnt;
  assign full  = (cnt >= CNT_W'(MAX_OUT));

endmodule

// File: rtl/vec_elem_seq.sv
// vec_elem_seq: element sequencer for multi-cycle vector instructions.
// Accepts one decoded vector instruction from ID, stalls the scalar front
// end, then issues one element operation per cycle to the shared lane
// until vl elements are issued and written back. In-flight elements are
// bounded by a credit counter; flush aborts the instruction.
// Ports:
//   clock, reset                  : clock, synchronous active-high reset
//   vec_valid / vec_ready         : instruction handshake with ID
//   vec_vd, vec_vs1, vec_vs2      : register fields of the instruction
//   csr_vl                        : vl from the CSR file, clamped to MAX_VL
//   elem_valid / elem_ready       : element handshake with the lane
//   elem_idx, elem_last           : element index, last-element flag
//   elem_vd, elem_vs1, elem_vs2   : latched register fields
//   wb_ack                        : one element completed writeback
//   flush                         : kill the current instruction
//   stall_pipe, busy              : hold IF/ID, sequencer not idle
//   done                          : one-cycle completion pulse
module vec_elem_seq
  import vec_elem_seq_pkg::*;
#(
  parameter int unsigned MAX_VL  = VSEQ_MAX_VL,
  parameter int unsigned MAX_OUT = VSEQ_MAX_OUT,
  parameter int unsigned VL_W    = $clog2(MAX_VL) + 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            vec_valid,
  output logic            vec_ready,
  input  logic [4:0]      vec_vd,
  input  logic [4:0]      vec_vs1,
  input  logic [4:0]      vec_vs2,
  input  logic [VL_W-1:0] csr_vl,
  output logic            elem_valid,
  input  logic            elem_ready,
  output logic [VL_W-1:0] elem_idx,
  output logic [4:0]      elem_vd,
  output logic [4:0]      elem_vs1,
  output logic [4:0]      elem_vs2,
  output logic            elem_last,
  input  logic            wb_ack,
  input  logic            flush,
  output logic            stall_pipe,
  output logic            busy,
  output logic            done
);

  localparam int unsigned CNT_W = $clog2(MAX_OUT) + 1;

  vseqState_e       state, stateNext;
  logic [VL_W-1:0]  vl, idx, vlClamp;
  logic [4:0]       vdReg, vs1Reg, vs2Reg;
  logic             doneReg, doneNext;
  logic [CNT_W-1:0] outCnt;
  logic             full;
  logic             vecReadyC, elemValidC, accept, xfer, ackEff, drainEmpty;
  logic             elemLast;

  assign vlClamp  = (csr_vl > VL_W'(MAX_VL)) ? VL_W'(MAX_VL) : csr_vl;
  assign elemLast = (idx == vl - VL_W'(1));

  vseq_credit_cnt #(
    .MAX_OUT(MAX_OUT),
    .CNT_W  (CNT_W)
  ) creditCnt (
    .clock(clock),
    .reset(reset),
    .inc  (xfer),
    .dec  (ackEff),
    .clr  (flush),
    .count(outCnt),
    .full (full)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= VSEQ_IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext  = state;
    vecReadyC  = 1'b0;
    elemValidC = 1'b0;
    doneNext   = 1'b0;
    ackEff     = wb_ack && (state != VSEQ_IDLE) && !flush;
    // Completion looks through a writeback landing in the same cycle.
    drainEmpty = (outCnt == '0) || ((outCnt == CNT_W'(1)) && ackEff);
    case (state)
      VSEQ_IDLE: begin
        vecReadyC = !reset && !flush;
        if (vec_valid && vecReadyC)
          stateNext = (vlClamp != '0) ? VSEQ_ISSUE : VSEQ_DRAIN;
      end
      VSEQ_ISSUE: begin
        elemValidC = !full && !flush;
        if (elemValidC && elem_ready && elemLast) stateNext = VSEQ_DRAIN;
      end
      VSEQ_DRAIN: begin
        if (drainEmpty && !flush) begin
          stateNext = VSEQ_IDLE;
          doneNext  = 1'b1;
        end
      end
      default: stateNext = VSEQ_IDLE;
    endcase
    if (flush) stateNext = VSEQ_IDLE;
    accept = vec_valid && vecReadyC;
    xfer   = elemValidC && elem_ready;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vl      <= '0;
      idx     <= '0;
      vdReg   <= '0;
      vs1Reg  <= '0;
      vs2Reg  <= '0;
      doneReg <= 1'b0;
    end else begin
      doneReg <= doneNext;
      if (accept) begin
        vl     <= vlClamp;
        idx    <= '0;
        vdReg  <= vec_vd;
        vs1Reg <= vec_vs1;
        vs2Reg <= vec_vs2;
      end else if (xfer) begin
        idx <= idx + VL_W'(1);
      end
    end
  end

  assign vec_ready  = vecReadyC;
  assign elem_valid = elemValidC;
  assign elem_idx   = idx;
  assign elem_vd    = vdReg;
  assign elem_vs1   = vs1Reg;
  assign elem_vs2   = vs2Reg;
  assign elem_last  = elemLast;
  assign busy       = (state != VSEQ_IDLE);
  assign stall_pipe = busy;
  assign done       = doneReg;

endmodule

// File: tb/tb_vec_elem_seq.sv
// Testbench for vec_elem_seq: directed scenarios followed by random
// traffic, checked cycle by cycle against a queue-based reference model.
module tb_vec_elem_seq;

  localparam int MAX_VL  = 32;
  localparam int MAX_OUT = 4;
  localparam int VL_W    = $clog2(MAX_VL) + 1;

  logic            clock = 1'b0;
  logic            reset, vec_valid, elem_ready, wb_ack, flush;
  logic [4:0]      vec_vd, vec_vs1, vec_vs2;
  logic [VL_W-1:0] csr_vl;
  logic            vec_ready, elem_valid, elem_last, stall_pipe, busy, done;
  logic [VL_W-1:0] elem_idx;
  logic [4:0]      elem_vd, elem_vs1, elem_vs2;

  always #5 clock = ~clock;

  vec_elem_seq #(
    .MAX_VL (MAX_VL),
    .MAX_OUT(MAX_OUT),
    .VL_W   (VL_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .vec_valid (vec_valid),
    .vec_ready (vec_ready),
    .vec_vd    (vec_vd),
    .vec_vs1   (vec_vs1),
    .vec_vs2   (vec_vs2),
    .csr_vl    (csr_vl),
    .elem_valid(elem_valid),
    .elem_ready(elem_ready),
    .elem_idx  (elem_idx),
    .elem_vd   (elem_vd),
    .elem_vs1  (elem_vs1),
    .elem_vs2  (elem_vs2),
    .elem_last (elem_last),
    .wb_ack    (wb_ack),
    .flush     (flush),
    .stall_pipe(stall_pipe),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    int       idx;
    bit [4:0] vd, vs1, vs2;
    bit       last;
  } elem_t;

  elem_t expQ[$];
  int    vecs = 0;
  int    errs = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: what the next cycle should look like.
  bit    mActive = 0, mDrain = 0, mDoneNow = 0;
  int    mOut = 0;
  bit    prevReset = 0, prevStall = 0;
  bit    xferFlag = 0;
  int    xferCount = 0;
  logic [VL_W+14:0] prevFields;

  always @(negedge clock) begin : monitor
    bit startAct, expValid, x, ack, newDone;
    int n;
    elem_t e;
    if (reset) begin
      check("vec_ready_in_reset", vec_ready, 0);
      expQ.delete();
      mActive = 0; mDrain = 0; mDoneNow = 0; mOut = 0;
      prevReset = 1; prevStall = 0; xferFlag = 0;
    end else begin
      if (prevReset) begin
        check("post_reset_outputs", {elem_idx, elem_vd, elem_vs1, elem_vs2, done}, '0);
      end
      prevReset = 0;
      startAct = mActive;
      expValid = mActive && !mDrain && (expQ.size() > 0) && (mOut < MAX_OUT) && !flush;
      check("elem_valid", elem_valid, expValid);
      check("busy", busy, mActive);
      check("stall_pipe", stall_pipe, mActive);
      check("done", done, mDoneNow);
      check("vec_ready", vec_ready, !mActive && !flush);
      if (prevStall)
        check("hold_while_stalled", {elem_idx, elem_vd, elem_vs1, elem_vs2}, prevFields);
      x = expValid && elem_ready;
      if (x) begin
        e = expQ.pop_front();
        check("element", {elem_idx, elem_vd, elem_vs1, elem_vs2, elem_last},
              {VL_W'(e.idx), e.vd, e.vs1, e.vs2, e.last});
        xferCount++;
      end
      xferFlag   = x;
      prevStall  = elem_valid && !elem_ready && !flush;
      prevFields = {elem_idx, elem_vd, elem_vs1, elem_vs2};
      newDone = 0;
      if (flush) begin
        expQ.delete();
        mOut = 0; mActive = 0; mDrain = 0;
      end else begin
        ack  = wb_ack && startAct && (mOut > 0);
        mOut = mOut + (x ? 1 : 0) - (ack ? 1 : 0);
        if (startAct && mDrain) begin
          if (mOut == 0) begin
            newDone = 1; mActive = 0; mDrain = 0;
          end
        end else if (startAct && x && expQ.size() == 0) begin
          mDrain = 1;
        end
        if (vec_valid && !startAct) begin
          n = (int'(csr_vl) > MAX_VL) ? MAX_VL : int'(csr_vl);
          for (int i = 0; i < n; i++) begin
            e.idx = i; e.vd = vec_vd; e.vs1 = vec_vs1; e.vs2 = vec_vs2;
            e.last = (i == n - 1);
            expQ.push_back(e);
          end
          mActive = 1;
          mDrain  = (n == 0);
        end
      end
      mDoneNow = newDone;
    end
  end

  // Lane writeback behaviour: 0 random, 1 one cycle after each transfer, 2 hold.
  int ackMode = 2;
  int ackPct  = 40;

  task automatic cyc();
    @(posedge clock);
    #1;
    case (ackMode)
      0:       wb_ack = ($urandom_range(0, 99) < ackPct);
      1:       wb_ack = xferFlag;
      default: ;
    endcase
  endtask

  task automatic issue(input int vlIn);
    vec_valid = 1;
    csr_vl    = VL_W'(vlIn);
    vec_vd    = 5'($urandom_range(0, 31));
    vec_vs1   = 5'($urandom_range(0, 31));
    vec_vs2   = 5'($urandom_range(0, 31));
    cyc();
    vec_valid = 0;
  endtask

  task automatic waitIdle(input int budget);
    int k = 0;
    while (busy !== 1'b0 && k < budget) begin
      cyc();
      k++;
    end
    check("idle_within_budget", busy, 0);
  endtask

  initial begin : guard
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int target, k;
    reset = 1; vec_valid = 0; elem_ready = 0; wb_ack = 0; flush = 0;
    vec_vd = 0; vec_vs1 = 0; vec_vs2 = 0; csr_vl = 0;
    repeat (3) cyc();
    reset = 0;
    cyc();

    // vl=4, lane always ready, writeback one cycle behind each transfer
    elem_ready = 1; ackMode = 1;
    issue(4);
    waitIdle(20);

    // vl=0 goes straight to drain
    issue(0);
    waitIdle(10);

    // credit limit: no writebacks, then a single one at T+7
    wb_ack = 0; ackMode = 2;
    issue(8);
    repeat (6) cyc();
    wb_ack = 1;
    cyc();
    wb_ack = 0;
    ackMode = 0; ackPct = 50;
    waitIdle(60);

    // lane stalls for three cycles at element 2
    ackMode = 1; elem_ready = 1;
    issue(6);
    cyc(); cyc();
    elem_ready = 0;
    repeat (3) cyc();
    elem_ready = 1;
    waitIdle(30);

    // flush at element 2, new instruction accepted on the following cycle
    issue(8);
    cyc(); cyc();
    flush = 1;
    cyc();
    flush = 0;
    issue(3);
    waitIdle(30);

    // vl clamped to MAX_VL, then reset while draining
    target = xferCount + MAX_VL;
    issue(40);
    k = 0;
    while (xferCount < target && k < 200) begin
      cyc();
      k++;
    end
    check("clamped_issue_count", xferCount, target);
    wb_ack = 0; ackMode = 2;
    cyc(); cyc();
    reset = 1;
    cyc();
    reset = 0;
    repeat (3) cyc();

    // random traffic
    ackMode = 0; ackPct = 40;
    for (int c = 0; c < 3000; c++) begin
      vec_valid  = ($urandom_range(0, 99) < 30);
      csr_vl     = VL_W'(($urandom_range(0, 9) == 0) ? $urandom_range(33, 63) : $urandom_range(0, 12));
      vec_vd     = 5'($urandom_range(0, 31));
      vec_vs1    = 5'($urandom_range(0, 31));
      vec_vs2    = 5'($urandom_range(0, 31));
      elem_ready = ($urandom_range(0, 99) < 75);
      flush      = ($urandom_range(0, 99) < 2);
      reset      = ($urandom_range(0, 199) == 0);
      cyc();
    end
    vec_valid = 0; flush = 0; reset = 0; elem_ready = 1; ackPct = 100;
    waitIdle(200);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
